// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: fixed XLEN+2 cycle latency (done one cycle after FIX), one op in flight.
// No queue: start is ignored while busy, flush aborts RUN/FIX without a done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] OVF_A = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  muldiv_op_e        op_q, op_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic              neg_q, neg_d;
  logic              divz_q, divz_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  muldiv_op_e      op_in;
  logic            a_signed, b_signed, sa, sb, is_div_in, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in;

  assign op_in     = muldiv_op_e'(funct3);
  assign a_signed  = op_in inside {MUL, MULH, MULHSU, DIV, REM};
  assign b_signed  = op_in inside {MUL, MULH, DIV, REM};
  assign sa        = a_signed & rs1_data[XLEN-1];
  assign sb        = b_signed & rs2_data[XLEN-1];
  assign a_mag     = sa ? -rs1_data : rs1_data;
  assign b_mag     = sb ? -rs2_data : rs2_data;
  assign is_div_in = funct3[2];
  assign is_div    = op_q inside {DIV, DIVU, REM, REMU};

  always_comb begin
    neg_in = 1'b0;
    case (op_in)
      MUL, MULH, DIV: neg_in = sa ^ sb;
      MULHSU, REM:    neg_in = sa;
      default:        neg_in = 1'b0;
    endcase
  end

  // Multiply: shift-add into the upper half, product shifts right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};

  // Divide: upper half is the partial remainder, quotient bits enter at the bottom.
  logic [XLEN:0]     div_sh, div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_sh   = prod_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quo, rem, fix_res;
  assign prod_neg = -prod_q;
  assign quo      = prod_q[XLEN-1:0];
  assign rem      = prod_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      MUL:                 fix_res = neg_q ? prod_neg[XLEN-1:0] : prod_q[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (divz_q)                    fix_res = '1;
        else if (op_q == DIV && ovf_q) fix_res = OVF_A;
        else                           fix_res = neg_q ? -quo : quo;
      end
      default: begin
        if (divz_q)                    fix_res = a_q;
        else if (op_q == REM && ovf_q) fix_res = '0;
        else                           fix_res = neg_q ? -rem : rem;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    ovf_d    = ovf_q;
    rd_d     = rd_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = RUN;
          cnt_d   = CW'(XLEN);
          op_d    = op_in;
          prod_d  = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
          opnd_d  = is_div_in ? b_mag : a_mag;
          a_d     = rs1_data;
          neg_d   = neg_in;
          divz_d  = (rs2_data == '0);
          ovf_d   = (rs1_data == OVF_A) && (&rs2_data);
          rd_d    = rd_addr;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          prod_d = is_div ? div_next : mul_next;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MUL;
      prod_q   <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Takes the two source operands read from the register file, computes the selected M-extension result over a fixed multi-cycle latency, and returns the result with its destination register address. `done` drives the register-file write enable, `rd_out` drives the write address, and `result` drives the write data. The pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand and result width; iteration count equals `XLEN`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `flush`  in  1: synchronous abort.
- `funct3`  in  3: operation select; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  in  XLEN: operand A (dividend / multiplicand).
- `rs2_data`  in  XLEN: operand B (divisor / multiplier).
- `rd_addr`  in  5: destination register, captured with the operands.
- `busy`  out  1: high while an operation is in flight.
- `done`  out  1: one-cycle pulse when the result is valid; this is the register-file write enable.
- `result`  out  XLEN: result; held until the next `done`.
- `rd_out`  out  5: captured `rd_addr`; held with `result`.

## Operation
- States:
  - IDLE: `start && !flush` captures operands, `funct3` and `rd_addr`, then goes to RUN.
  - RUN: performs `XLEN` iterations, counted by a down-counter of width `clog2(XLEN)+1`, then goes to FIX.
  - FIX: applies sign correction and special cases, registers `result`, pulses `done`, then goes to IDLE.
- Operand prep at capture:
  - Signed operands are replaced by their magnitudes.
  - Result sign flag = sign(A) xor sign(B) for MUL/MULH/DIV.
  - For MULHSU, only A is signed.
  - For REM, the sign follows A.
- Multiply: radix-2 shift-add on a 2·XLEN product register.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits after two's-complement negation of the full 2·XLEN product when the sign flag is set.
- Divide: restoring algorithm, one quotient bit per iteration.
  - XLEN-bit remainder register plus 1 guard bit.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases resolved in FIX; latency is unchanged:
  - Divide by zero: quotient = all ones (both signed and unsigned); remainder = A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` while `busy`: ignored. There is no queue; upstream must stall.
- `flush`:
  - In RUN or FIX: return to IDLE at the next edge, with no `done`.
  - `result` and `rd_out` keep their previous values.
  - `flush` and `start` in the same IDLE cycle: `flush` wins, and nothing is captured.
- `rd_addr` = 0 completes normally. The register file discards writes to x0.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `rd_out` 0, counter 0.
- Assertion of `rst_n` low in any state aborts immediately; outputs return to their reset values asynchronously.
- Latency:
  - `start` sampled at edge E0.
  - `busy` is high from E0 until edge E0+XLEN+1.
  - `done` is high for exactly the cycle following edge E0+XLEN+1, which is 33 cycles after E0 at XLEN=32.
  - `result` and `rd_out` become valid in the same cycle as `done`.
- `busy` is low in the `done` cycle. A new `start` in that cycle is accepted, giving back-to-back throughput of XLEN+2 cycles.
- Operand inputs need only be valid in the `start` cycle.

## Structure
- Package `muldiv_pkg`:
  - `funct3` enum `muldiv_op_e` (MUL..REMU, values 0–7).
  - State enum `muldiv_state_e` (IDLE, RUN, FIX).
  - Constant `DIV_OVF_DIVIDEND` = 0x80000000.
- Single module with no sub-module. The shared product/remainder shift register and the counter are inline.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD, rd=5) → after 33 cycles `done`=1, `result` 0xFFFFFFEB, `rd_out` 5; `busy` low in the `done` cycle.
- MULH/MULHSU/MULHU with A = B = 0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero, A = 0x12345678: DIV/DIVU → 0xFFFFFFFF, REM/REMU → 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- `flush` at cycle 10 of RUN → no `done`, `busy` low next cycle, `result` unchanged. `start` asserted while `busy` → ignored. `start` + `flush` in IDLE → nothing captured.
- `rst_n` asserted low mid-RUN → `busy` 0, `result` 0 immediately. Back-to-back `start` in the `done` cycle → second `done` arrives 33 cycles later.
